// File: rtl/alu_cmd_ctrl_if.sv
// Handshake/bus bundle between the ALU command controller, the UART RX/TX path and the ALU.
// The slave modport is the controller's view; master is the surrounding system's view.
interface alu_cmd_ctrl_if #(
    parameter int Input_data_width  = 8,
    parameter int Output_data_width = 16
);
    logic [Input_data_width-1:0]  RX_P_DATA;
    logic                         RX_D_VLD;
    logic [Input_data_width-1:0]  A;
    logic [Input_data_width-1:0]  B;
    logic [3:0]                   ALU_FUN;
    logic                         ALU_EN;
    logic [Output_data_width-1:0] ALU_OUT;
    logic                         OUT_VALID;
    logic [7:0]                   TX_P_DATA;
    logic                         TX_VALID;
    logic                         TX_READY;
    logic                         CTRL_BUSY;
    logic                         TIMEOUT_ERR;
    logic                         RX_DROP;

    modport slave (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_READY,
        output A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_VALID, CTRL_BUSY, TIMEOUT_ERR, RX_DROP
    );

    modport master (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_READY,
        input  A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_VALID, CTRL_BUSY, TIMEOUT_ERR, RX_DROP
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses 0xCC/0xDD command frames from the RX byte stream, fires the ALU, and
// returns the result LSB-first (or 0xEE on ALU timeout) over a valid/ready TX port.
module alu_cmd_ctrl #(
    parameter int Input_data_width  = 8,
    parameter int Output_data_width = 16,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input logic CLK,
    input logic RST,
    alu_cmd_ctrl_if.slave bus
);
    localparam int RES_BYTES = Output_data_width / 8;
    localparam int IDX_W     = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

    localparam logic [7:0] HDR_FULL  = 8'hCC;
    localparam logic [7:0] HDR_REUSE = 8'hDD;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, REQ, WAIT, SEND, ERR
    } state_t;

    state_t                    state;
    logic [RES_BYTES-1:0][7:0] result;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                tmo_cnt;
    logic [7:0]                rx_byte;
    logic                      tx_fire;
    logic                      last_byte;
    logic                      tmo_hit;

    assign rx_byte   = bus.RX_P_DATA[7:0];
    assign tx_fire   = bus.TX_VALID && bus.TX_READY;
    assign last_byte = (idx == IDX_W'(RES_BYTES - 1));
    assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            result          <= '0;
            idx             <= '0;
            tmo_cnt         <= '0;
            bus.A           <= '0;
            bus.B           <= '0;
            bus.ALU_FUN     <= '0;
            bus.ALU_EN      <= 1'b0;
            bus.TX_P_DATA   <= '0;
            bus.TX_VALID    <= 1'b0;
            bus.CTRL_BUSY   <= 1'b0;
            bus.TIMEOUT_ERR <= 1'b0;
            bus.RX_DROP     <= 1'b0;
        end else begin
            bus.ALU_EN      <= 1'b0;
            bus.TIMEOUT_ERR <= 1'b0;
            bus.RX_DROP     <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.RX_D_VLD && rx_byte == HDR_FULL) begin
                        state         <= GET_A;
                        bus.CTRL_BUSY <= 1'b1;
                    end else if (bus.RX_D_VLD && rx_byte == HDR_REUSE) begin
                        state         <= GET_FUN;
                        bus.CTRL_BUSY <= 1'b1;
                    end
                end

                GET_A: begin
                    if (bus.RX_D_VLD) begin
                        bus.A <= bus.RX_P_DATA;
                        state <= GET_B;
                    end
                end

                GET_B: begin
                    if (bus.RX_D_VLD) begin
                        bus.B <= bus.RX_P_DATA;
                        state <= GET_FUN;
                    end
                end

                // ALU_EN is registered here so it is high exactly while in REQ
                GET_FUN: begin
                    if (bus.RX_D_VLD) begin
                        bus.ALU_FUN <= rx_byte[3:0];
                        bus.ALU_EN  <= 1'b1;
                        state       <= REQ;
                    end
                end

                REQ: begin
                    bus.RX_DROP <= bus.RX_D_VLD;
                    tmo_cnt     <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    bus.RX_DROP <= bus.RX_D_VLD;
                    if (bus.OUT_VALID) begin
                        result        <= bus.ALU_OUT;
                        idx           <= '0;
                        bus.TX_P_DATA <= bus.ALU_OUT[7:0];
                        bus.TX_VALID  <= 1'b1;
                        state         <= SEND;
                    end else if (tmo_hit) begin
                        bus.TIMEOUT_ERR <= 1'b1;
                        bus.TX_P_DATA   <= ERR_BYTE;
                        bus.TX_VALID    <= 1'b1;
                        state           <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                // TX_P_DATA only moves on an accepted handshake, so it is stable under backpressure
                SEND: begin
                    bus.RX_DROP <= bus.RX_D_VLD;
                    if (tx_fire) begin
                        if (last_byte) begin
                            bus.TX_VALID  <= 1'b0;
                            bus.CTRL_BUSY <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            idx           <= idx + 1'b1;
                            bus.TX_P_DATA <= result[idx + 1'b1];
                        end
                    end
                end

                ERR: begin
                    bus.RX_DROP <= bus.RX_D_VLD;
                    if (tx_fire) begin
                        bus.TX_VALID  <= 1'b0;
                        bus.CTRL_BUSY <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.TX_VALID  <= 1'b0;
                    bus.CTRL_BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: a frame-level model predicts operands, ALU pulses
// and the TX byte stream; a negedge monitor compares the DUT against it every cycle.
module tb_alu_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_ctrl_if #(.Input_data_width(8), .Output_data_width(16)) bus ();

    alu_cmd_ctrl #(
        .Input_data_width (8),
        .Output_data_width(16),
        .TIMEOUT_CYCLES   (15)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // model state: last loaded operands, expected TX bytes, ALU behaviour
    logic [7:0]  exp_a = '0;
    logic [7:0]  exp_b = '0;
    logic [3:0]  exp_fun = '0;
    logic [7:0]  exp_tx[$];
    int          alu_lat = 1;
    logic [15:0] alu_res = '0;

    int en_count = 0, drop_count = 0, tmo_count = 0;
    int cyc = 0, en_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic expect_result(input logic [15:0] res, input bit tmo);
        alu_res = res;
        if (tmo) begin
            exp_tx.push_back(8'hEE);
        end else begin
            exp_tx.push_back(res[7:0]);
            exp_tx.push_back(res[15:8]);
        end
    endtask

    task automatic frame_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                            input logic [15:0] res, input bit tmo);
        exp_a   = a;
        exp_b   = b;
        exp_fun = f[3:0];
        expect_result(res, tmo);
        rx(8'hCC); rx(a); rx(b); rx(f);
    endtask

    task automatic frame_dd(input logic [7:0] f, input logic [15:0] res, input bit tmo);
        exp_fun = f[3:0];
        expect_result(res, tmo);
        rx(8'hDD); rx(f);
    endtask

    task automatic wait_idle(input string name, input bit toggle);
        int n = 0;
        while ((bus.CTRL_BUSY || exp_tx.size() != 0) && n < 300) begin
            if (toggle) bus.TX_READY = ~bus.TX_READY;
            tick();
            n++;
        end
        bus.TX_READY = 1'b1;
        chk({name, "_busy_low"}, bus.CTRL_BUSY, 0);
        chk({name, "_tx_drained"}, exp_tx.size(), 0);
    endtask

    // ALU model: answers alu_lat cycles after the ALU_EN cycle, never if alu_lat == 0
    initial begin
        bus.OUT_VALID = 1'b0;
        bus.ALU_OUT   = '0;
        forever begin
            tick();
            if (bus.ALU_EN && !rst && alu_lat > 0) begin
                repeat (alu_lat) tick();
                bus.ALU_OUT   = alu_res;
                bus.OUT_VALID = 1'b1;
                tick();
                bus.OUT_VALID = 1'b0;
            end
        end
    end

    // per-cycle monitor
    initial begin
        logic       prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_en   = 1'b0;
        logic       prev_tmo  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold = 1'b0;
                prev_en   = 1'b0;
                prev_tmo  = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("tx_valid_held", bus.TX_VALID, 1);
                    chk("tx_data_held", bus.TX_P_DATA, prev_data);
                end
                if (bus.TX_VALID && bus.TX_READY) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got byte %0h expected none (cycle %0d)", bus.TX_P_DATA, cyc);
                    end else begin
                        chk("tx_byte", bus.TX_P_DATA, exp_tx.pop_front());
                    end
                end
                if (bus.ALU_EN) begin
                    chk("alu_en_single", prev_en, 0);
                    chk("alu_a", bus.A, exp_a);
                    chk("alu_b", bus.B, exp_b);
                    chk("alu_fun", bus.ALU_FUN, exp_fun);
                    en_count++;
                    en_cyc = cyc;
                end
                if (bus.TIMEOUT_ERR) begin
                    chk("timeout_single", prev_tmo, 0);
                    chk("timeout_delay", cyc - en_cyc, 16);
                    tmo_count++;
                end
                if (bus.RX_DROP) drop_count++;
                prev_hold = bus.TX_VALID && !bus.TX_READY;
                prev_data = bus.TX_P_DATA;
                prev_en   = bus.ALU_EN;
                prev_tmo  = bus.TIMEOUT_ERR;
            end
        end
    end

    initial begin
        int e0, d0, t0;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_READY  = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_a", bus.A, 0);
        chk("rst_b", bus.B, 0);
        chk("rst_fun", bus.ALU_FUN, 0);
        chk("rst_outs", {bus.ALU_EN, bus.TX_VALID, bus.CTRL_BUSY, bus.TIMEOUT_ERR, bus.RX_DROP}, 0);
        chk("rst_tx_data", bus.TX_P_DATA, 0);
        rst = 1'b0;
        tick();

        // full add frame
        e0 = en_count;
        frame_cc(8'h05, 8'h03, 8'h00, 16'h0008, 1'b0);
        wait_idle("full_add", 1'b0);
        chk("full_add_a", bus.A, 8'h05);
        chk("full_add_b", bus.B, 8'h03);
        chk("full_add_fun", bus.ALU_FUN, 4'h0);
        chk("full_add_en_pulses", en_count - e0, 1);

        // reuse operands, entered in the first IDLE cycle after the previous frame
        e0 = en_count;
        frame_dd(8'h02, 16'h000F, 1'b0);
        wait_idle("reuse", 1'b0);
        chk("reuse_fun", bus.ALU_FUN, 4'h2);
        chk("reuse_a", bus.A, 8'h05);
        chk("reuse_b", bus.B, 8'h03);
        chk("reuse_en_pulses", en_count - e0, 1);

        // upper nibble of FUN is ignored
        frame_dd(8'hA9, 16'h1357, 1'b0);
        wait_idle("fun_nibble", 1'b0);
        chk("fun_nibble_fun", bus.ALU_FUN, 4'h9);

        // backpressure: hold, then toggle TX_READY
        bus.TX_READY = 1'b0;
        frame_cc(8'h12, 8'h34, 8'h01, 16'h1234, 1'b0);
        repeat (7) tick();
        chk("bp_valid", bus.TX_VALID, 1);
        chk("bp_data", bus.TX_P_DATA, 8'h34);
        wait_idle("backpressure", 1'b1);

        // ALU never answers
        alu_lat = 0;
        t0 = tmo_count;
        frame_dd(8'h03, 16'h0000, 1'b1);
        wait_idle("timeout", 1'b0);
        chk("timeout_pulses", tmo_count - t0, 1);
        alu_lat = 1;

        // noise in IDLE is silent; a byte during WAIT is dropped
        d0 = drop_count;
        rx(8'h7A);
        tick();
        chk("noise_no_drop", drop_count - d0, 0);
        chk("noise_idle", bus.CTRL_BUSY, 0);
        alu_lat = 3;
        frame_dd(8'h05, 16'hBEC3, 1'b0);
        tick();
        rx(8'h41);
        wait_idle("wait_drop", 1'b0);
        chk("wait_drop_count", drop_count - d0, 1);
        alu_lat = 1;

        // reset mid-frame, then reuse frame with cleared operands
        rx(8'hCC);
        rx(8'h11);
        rst = 1'b1;
        tick();
        chk("midrst_a", bus.A, 0);
        chk("midrst_outs", {bus.ALU_EN, bus.TX_VALID, bus.CTRL_BUSY, bus.TIMEOUT_ERR, bus.RX_DROP}, 0);
        tick();
        rst = 1'b0;
        exp_a = '0;
        exp_b = '0;
        e0 = en_count;
        frame_dd(8'h00, 16'h00AB, 1'b0);
        wait_idle("post_rst", 1'b0);
        chk("post_rst_a", bus.A, 8'h00);
        chk("post_rst_b", bus.B, 8'h00);
        chk("post_rst_fun", bus.ALU_FUN, 4'h0);
        chk("post_rst_en_pulses", en_count - e0, 1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
